fifo_256_rr_sched: RTL and testbench

Round-robin scheduler that drains four 256-bit source FIFOs (fifo_256_xxx instances, one per processing lane) into a single shared 256-bit sink FIFO. Each grant is held for a burst of up to BURST_LEN words, so a lane's results stay contiguous in the sink stream. The block sits between the lane result buffers and the common output/memory-write buffer, and is the only agent driving their rd_en and the sink's wr_en.

---
 rtl/fifo_256_rr_sched_if.sv | 17 +
 rtl/fifo_256_rr_sched.sv | 81 ++++++++
 tb/tb_fifo_256_rr_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_256_rr_sched_if.sv
// fifo_256_rr_sched_if: lane source FIFO read ports and shared sink FIFO write port
//   src_dout  [1023:0] lane i word on [256*i+255:256*i], valid the cycle after src_rd_en[i]
//   src_empty [3:0]    lane FIFO empty flags
//   src_rd_en [3:0]    lane FIFO read strobes (scheduler drives)
//   dst_din   [255:0]  sink write data (scheduler drives)
//   dst_wr_en          sink write strobe (scheduler drives)
//   dst_full           sink threshold-full flag
interface fifo_256_rr_sched_if;
  logic [1023:0] src_dout;
  logic [3:0] src_empty;
  logic [3:0] src_rd_en;
  logic [255:0] dst_din;
  logic dst_wr_en;
  logic dst_full;
  modport master (input src_dout, src_empty, dst_full, output src_rd_en, dst_din, dst_wr_en);
  modport slave (output src_dout, src_empty, dst_full, input src_rd_en, dst_din, dst_wr_en);
endinterface

// File: rtl/fifo_256_rr_sched.sv
// fifo_256_rr_sched: round-robin burst scheduler draining four lane FIFOs into one sink FIFO
//   clk    system clock
//   rst_n  synchronous active-low reset
//   ch_en  per-lane enable mask
//   bus    lane read ports and sink write port (master side)
//   grant  one-hot lane currently owning the sink, 0 when idle
//   busy   high while a burst is active or words are still in flight
module fifo_256_rr_sched #(
  parameter int BURST_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [3:0] ch_en,
  fifo_256_rr_sched_if.master bus,
  output logic [3:0] grant,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  localparam logic [7:0] LEN = 8'(BURST_LEN);
  state_t state, state_nxt;
  logic [1:0] g, last, sel, cand, sel_d1;
  logic [7:0] cnt;
  logic found, rd, burst_end, rd_d1;
  // search last+1 .. last+4 (mod 4); walking the offsets downward leaves the nearest hit in sel
  always_comb begin
    sel = last;
    cand = last;
    found = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (ch_en[cand] && !bus.src_empty[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    rd = state == BURST && ch_en[g] && !bus.src_empty[g] && !bus.dst_full && cnt < LEN;
    bus.src_rd_en = rd ? 4'b0001 << g : 4'b0000;
    // a stalled burst (full, not empty) stays put; a disabled or drained lane ends it
    burst_end = !ch_en[g] || (rd && cnt == LEN - 8'd1) || (!rd && bus.src_empty[g]);
    state_nxt = state == IDLE ? (found ? BURST : IDLE) :
                state == BURST ? (burst_end ? DONE : BURST) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      g <= '0;
      last <= 2'd3;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        grant <= 4'b0001 << sel;
        g <= sel;
        cnt <= '0;
      end
      if (rd) cnt <= cnt + 8'd1;
      if (state == DONE) begin
        last <= g;
        grant <= '0;
      end
    end
  end
  // two-stage datapath: the lane word appears the cycle after its read, then is registered out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_d1 <= 1'b0;
      sel_d1 <= '0;
      bus.dst_wr_en <= 1'b0;
      bus.dst_din <= '0;
    end else begin
      rd_d1 <= rd;
      sel_d1 <= g;
      bus.dst_wr_en <= rd_d1;
      if (rd_d1) bus.dst_din <= bus.src_dout[{sel_d1, 8'h00} +: 256];
    end
  end
  assign busy = state != IDLE || rd_d1 || bus.dst_wr_en;
endmodule

// File: tb/tb_fifo_256_rr_sched.sv
// tb_fifo_256_rr_sched: directed self-checking bench for the round-robin lane scheduler
`timescale 1ns/1ps
module tb_fifo_256_rr_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] ch_en, ch_en2, grant, grant2;
  logic busy, busy2;
  int n_chk = 0;
  int n_fail = 0;
  fifo_256_rr_sched_if bus ();
  fifo_256_rr_sched_if bus2 ();
  fifo_256_rr_sched #(.BURST_LEN(16)) dut (.clk(clk), .rst_n(rst_n), .ch_en(ch_en), .bus(bus), .grant(grant), .busy(busy));
  fifo_256_rr_sched #(.BURST_LEN(1)) dut2 (.clk(clk), .rst_n(rst_n), .ch_en(ch_en2), .bus(bus2), .grant(grant2), .busy(busy2));
  always #5 clk = ~clk;
  logic [255:0] mem [4][256];
  logic [255:0] dout [4];
  int head [4] = '{0, 0, 0, 0};
  int tail [4] = '{0, 0, 0, 0};
  assign bus.src_dout = {dout[3], dout[2], dout[1], dout[0]};
  assign bus.src_empty = {head[3] == tail[3], head[2] == tail[2], head[1] == tail[1], head[0] == tail[0]};
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (bus.src_rd_en[i]) begin
        dout[i] <= mem[i][head[i] % 256];
        head[i] <= head[i] + 1;
      end
  int cyc = 0, nrd = 0, nwr = 0, ng = 0, bcnt = 0, onehot_bad = 0, rd1_seen = 0;
  int rd_cyc [1024];
  int wr_cyc [1024];
  logic [255:0] wr_data [1024];
  int gl_len [64];
  logic [3:0] gl_grant [64];
  logic [3:0] glast = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (|bus.src_rd_en) begin
      rd_cyc[nrd] <= cyc;
      nrd <= nrd + 1;
      bcnt <= bcnt + 1;
    end
    if ($countones(bus.src_rd_en) > 1) onehot_bad <= onehot_bad + 1;
    if (bus.src_rd_en[1]) rd1_seen <= rd1_seen + 1;
    if (bus.dst_wr_en) begin
      wr_cyc[nwr] <= cyc;
      wr_data[nwr] <= bus.dst_din;
      nwr <= nwr + 1;
    end
    glast <= grant;
    if (grant == 4'b0 && glast != 4'b0) begin
      gl_grant[ng] <= glast;
      gl_len[ng] <= bcnt;
      ng <= ng + 1;
      bcnt <= 0;
    end
  end
  function automatic logic [255:0] mk(int lane, int seq);
    logic [15:0] t;
    t = {8'(lane), 8'(seq)};
    return {16{t}};
  endfunction
  task automatic fill(int lane, int n);
    for (int k = 0; k < n; k++) begin
      mem[lane][tail[lane] % 256] = mk(lane, tail[lane]);
      tail[lane] = tail[lane] + 1;
    end
  endtask
  task automatic wait_wr(int target, int budget);
    for (int t = 0; t < budget && nwr < target; t++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask
  task automatic wait_rd(int target, int budget);
    for (int t = 0; t < budget && nrd < target; t++) @(negedge clk);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    ch_en = 4'hf;
    ch_en2 = 4'hf;
    bus.dst_full = 1'b0;
    bus2.dst_full = 1'b0;
    bus2.src_empty = 4'hf;
    bus2.src_dout = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.src_rd_en !== 4'b0) begin n_fail++; $display("FAIL reset src_rd_en got %b want 0000", bus.src_rd_en); end
    n_chk++; if (bus.dst_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset dst_wr_en got %b want 0", bus.dst_wr_en); end
    n_chk++; if (bus.dst_din !== 256'b0) begin n_fail++; $display("FAIL reset dst_din got %h want 0", bus.dst_din); end
    n_chk++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset grant got %b want 0000", grant); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
    n_chk++; if ({grant2, busy2, bus2.dst_wr_en} !== 6'b0) begin n_fail++; $display("FAIL reset dut2 grant/busy/wr got %b want 000000", {grant2, busy2, bus2.dst_wr_en}); end
    rst_n = 1'b1;
  endtask
  task automatic test_single_lane;
    int b, rb, gb, s;
    int el [3] = '{16, 16, 8};
    b = nwr; rb = nrd; gb = ng; s = tail[0];
    fill(0, 40);
    wait_wr(b + 40, 400);
    n_chk++; if (nwr - b !== 40) begin n_fail++; $display("FAIL single write count got %0d want 40", nwr - b); end
    for (int k = 0; k < 40; k++) begin
      n_chk++; if (wr_data[b + k] !== mk(0, s + k)) begin n_fail++; $display("FAIL single data[%0d] got %h want %h", k, wr_data[b + k], mk(0, s + k)); end
      n_chk++; if (wr_cyc[b + k] - rd_cyc[rb + k] !== 2) begin n_fail++; $display("FAIL single latency[%0d] got %0d want 2", k, wr_cyc[b + k] - rd_cyc[rb + k]); end
    end
    n_chk++; if (ng - gb !== 3) begin n_fail++; $display("FAIL single burst count got %0d want 3", ng - gb); end
    for (int j = 0; j < 3; j++) begin
      n_chk++; if (gl_grant[gb + j] !== 4'b0001) begin n_fail++; $display("FAIL single grant[%0d] got %b want 0001", j, gl_grant[gb + j]); end
      n_chk++; if (gl_len[gb + j] !== el[j]) begin n_fail++; $display("FAIL single burst len[%0d] got %0d want %0d", j, gl_len[gb + j], el[j]); end
    end
  endtask
  task automatic test_all_lanes;
    int b, gb, lane;
    int s [4];
    logic [3:0] eg;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b = nwr; gb = ng;
    for (int i = 0; i < 4; i++) begin
      s[i] = tail[i];
      fill(i, 32);
    end
    wait_wr(b + 128, 800);
    n_chk++; if (nwr - b !== 128) begin n_fail++; $display("FAIL all write count got %0d want 128", nwr - b); end
    n_chk++; if (ng - gb !== 8) begin n_fail++; $display("FAIL all burst count got %0d want 8", ng - gb); end
    for (int j = 0; j < 8; j++) begin
      lane = j % 4;
      eg = 4'b0001 << lane;
      n_chk++; if (gl_grant[gb + j] !== eg) begin n_fail++; $display("FAIL all grant[%0d] got %b want %b", j, gl_grant[gb + j], eg); end
      n_chk++; if (gl_len[gb + j] !== 16) begin n_fail++; $display("FAIL all burst len[%0d] got %0d want 16", j, gl_len[gb + j]); end
      for (int k = 0; k < 16; k++) begin
        n_chk++; if (wr_data[b + 16 * j + k] !== mk(lane, s[lane] + 16 * (j / 4) + k)) begin n_fail++; $display("FAIL all data[%0d] got %h want %h", 16 * j + k, wr_data[b + 16 * j + k], mk(lane, s[lane] + 16 * (j / 4) + k)); end
      end
    end
  endtask
  task automatic test_stall;
    int b, rb, gb, s;
    b = nwr; rb = nrd; gb = ng; s = tail[0];
    fill(0, 16);
    wait_rd(rb + 5, 50);
    bus.dst_full = 1'b1;
    #1;
    n_chk++; if (nrd - rb !== 5) begin n_fail++; $display("FAIL stall reads before full got %0d want 5", nrd - rb); end
    n_chk++; if (nwr - b !== 3) begin n_fail++; $display("FAIL stall writes before full got %0d want 3", nwr - b); end
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (bus.src_rd_en !== 4'b0) begin n_fail++; $display("FAIL stall src_rd_en cycle %0d got %b want 0000", i, bus.src_rd_en); end
      n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL stall grant cycle %0d got %b want 0001", i, grant); end
      @(negedge clk);
    end
    bus.dst_full = 1'b0;
    n_chk++; if (nwr - b !== 5) begin n_fail++; $display("FAIL stall writes after full got %0d want 5", nwr - b); end
    n_chk++; if (nrd - rb !== 5) begin n_fail++; $display("FAIL stall reads held got %0d want 5", nrd - rb); end
    wait_wr(b + 16, 200);
    n_chk++; if (ng - gb !== 1 || gl_len[gb] !== 16) begin n_fail++; $display("FAIL stall burst got %0d bursts len %0d want 1 len 16", ng - gb, gl_len[gb]); end
    for (int k = 0; k < 16; k++) begin
      n_chk++; if (wr_data[b + k] !== mk(0, s + k)) begin n_fail++; $display("FAIL stall data[%0d] got %h want %h", k, wr_data[b + k], mk(0, s + k)); end
    end
  endtask
  task automatic test_ch_mask;
    int b, rb, gb, r1;
    logic [3:0] eg [3] = '{4'b1000, 4'b0010, 4'b1000};
    int el [3] = '{16, 4, 4};
    b = nwr; rb = nrd; gb = ng; r1 = rd1_seen;
    ch_en = 4'b1101;
    fill(1, 4);
    fill(3, 20);
    wait_rd(rb + 8, 50);
    n_chk++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL mask grant got %b want 1000", grant); end
    n_chk++; if (rd1_seen !== r1) begin n_fail++; $display("FAIL mask lane1 reads got %0d want 0", rd1_seen - r1); end
    ch_en = 4'hf;
    wait_wr(b + 24, 300);
    n_chk++; if (ng - gb !== 3) begin n_fail++; $display("FAIL mask burst count got %0d want 3", ng - gb); end
    for (int j = 0; j < 3; j++) begin
      n_chk++; if (gl_grant[gb + j] !== eg[j] || gl_len[gb + j] !== el[j]) begin n_fail++; $display("FAIL mask burst[%0d] got %b/%0d want %b/%0d", j, gl_grant[gb + j], gl_len[gb + j], eg[j], el[j]); end
    end
    n_chk++; if (rd1_seen - r1 !== 4) begin n_fail++; $display("FAIL mask lane1 reads after enable got %0d want 4", rd1_seen - r1); end
  endtask
  task automatic test_reset_mid;
    int b, rb, gb, s1, s2;
    b = nwr; rb = nrd; gb = ng; s2 = tail[2]; s1 = tail[1];
    fill(2, 20);
    wait_rd(rb + 7, 50);
    n_chk++; if (nrd - rb !== 7 || grant !== 4'b0100) begin n_fail++; $display("FAIL rstmid pre reads/grant got %0d/%b want 7/0100", nrd - rb, grant); end
    rst_n = 1'b0;
    fill(1, 3);
    @(negedge clk);
    n_chk++; if (bus.src_rd_en !== 4'b0) begin n_fail++; $display("FAIL rstmid src_rd_en got %b want 0000", bus.src_rd_en); end
    n_chk++; if (bus.dst_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid dst_wr_en got %b want 0", bus.dst_wr_en); end
    n_chk++; if (grant !== 4'b0) begin n_fail++; $display("FAIL rstmid grant got %b want 0000", grant); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid busy got %b want 0", busy); end
    rst_n = 1'b1;
    wait_wr(b + 21, 300);
    n_chk++; if (nwr - b !== 21) begin n_fail++; $display("FAIL rstmid write count got %0d want 21", nwr - b); end
    n_chk++; if (ng - gb !== 3) begin n_fail++; $display("FAIL rstmid burst count got %0d want 3", ng - gb); end
    n_chk++; if (gl_grant[gb + 1] !== 4'b0010 || gl_len[gb + 1] !== 3) begin n_fail++; $display("FAIL rstmid first grant got %b/%0d want 0010/3", gl_grant[gb + 1], gl_len[gb + 1]); end
    n_chk++; if (gl_grant[gb + 2] !== 4'b0100 || gl_len[gb + 2] !== 12) begin n_fail++; $display("FAIL rstmid second grant got %b/%0d want 0100/12", gl_grant[gb + 2], gl_len[gb + 2]); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (wr_data[b + 6 + k] !== mk(1, s1 + k)) begin n_fail++; $display("FAIL rstmid lane1 data[%0d] got %h want %h", k, wr_data[b + 6 + k], mk(1, s1 + k)); end
    end
    for (int k = 0; k < 12; k++) begin
      n_chk++; if (wr_data[b + 9 + k] !== mk(2, s2 + 8 + k)) begin n_fail++; $display("FAIL rstmid lane2 data[%0d] got %h want %h", k, wr_data[b + 9 + k], mk(2, s2 + 8 + k)); end
    end
  endtask
  task automatic test_burst_one;
    logic [255:0] w;
    w = mk(2, 200);
    @(negedge clk);
    bus2.src_empty = 4'b1011;
    #1;
    n_chk++; if (grant2 !== 4'b0 || bus2.src_rd_en !== 4'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL one idle grant/rd/busy got %b/%b/%b want 0000/0000/0", grant2, bus2.src_rd_en, busy2); end
    @(negedge clk);
    n_chk++; if (grant2 !== 4'b0100 || bus2.src_rd_en !== 4'b0100 || busy2 !== 1'b1) begin n_fail++; $display("FAIL one burst grant/rd/busy got %b/%b/%b want 0100/0100/1", grant2, bus2.src_rd_en, busy2); end
    bus2.src_dout = '0;
    bus2.src_dout[767:512] = w;
    @(negedge clk);
    n_chk++; if (grant2 !== 4'b0100 || bus2.src_rd_en !== 4'b0 || bus2.dst_wr_en !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL one done grant/rd/wr/busy got %b/%b/%b/%b want 0100/0000/0/1", grant2, bus2.src_rd_en, bus2.dst_wr_en, busy2); end
    bus2.src_empty = 4'hf;
    @(negedge clk);
    n_chk++; if (grant2 !== 4'b0 || bus2.dst_wr_en !== 1'b1 || busy2 !== 1'b1) begin n_fail++; $display("FAIL one write grant/wr/busy got %b/%b/%b want 0000/1/1", grant2, bus2.dst_wr_en, busy2); end
    n_chk++; if (bus2.dst_din !== w) begin n_fail++; $display("FAIL one data got %h want %h", bus2.dst_din, w); end
    @(negedge clk);
    n_chk++; if (grant2 !== 4'b0 || bus2.dst_wr_en !== 1'b0 || busy2 !== 1'b0 || bus2.src_rd_en !== 4'b0) begin n_fail++; $display("FAIL one after grant/wr/busy/rd got %b/%b/%b/%b want 0000/0/0/0000", grant2, bus2.dst_wr_en, busy2, bus2.src_rd_en); end
  endtask
  task automatic test_onehot;
    n_chk++; if (onehot_bad !== 0) begin n_fail++; $display("FAIL onehot multi-read cycles got %0d want 0", onehot_bad); end
  endtask
  initial begin
    test_reset;
    test_single_lane;
    test_all_lanes;
    test_stall;
    test_ch_mask;
    test_reset_mid;
    test_burst_one;
    test_onehot;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
